// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the traffic controller front end.
package traffic_pkg;

    localparam int NUM_ROADS              = 4;
    localparam int DEFAULT_ASSERT_CYCLES  = 8;
    localparam int DEFAULT_RELEASE_CYCLES = 16;
    localparam int DEFAULT_STUCK_CYCLES   = 1024;

    // One bit per road.
    typedef logic [NUM_ROADS-1:0] road_mask_t;

    // Width of a counter that must hold values up to max(a, b).
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/jam_sensor_conditioner_if.sv
// One road's detector channel: raw field input in, conditioned level,
// rise pulse and stuck-fault flag out. There is no handshake: all signals
// are levels sampled every clock by whoever consumes them.
interface jam_sensor_conditioner_if;
    logic raw;
    logic jam;
    logic rise;
    logic fault;

    // Field/consumer side: drives the raw detector, observes conditioned outputs.
    modport master (output raw, input jam, rise, fault);
    // Conditioner side: reads the raw detector, drives conditioned outputs.
    modport slave  (input raw, output jam, rise, fault);
endinterface

// File: rtl/jam_debounce_ch.sv
// One jam-detector channel: 2-flop synchronizer, symmetric-hysteresis
// persistence filter, registered rise pulse and, when STUCK_DETECT_EN is
// defined, a sticky stuck-asserted fault that masks the channel's outputs.
module jam_debounce_ch
    import traffic_pkg::*;
#(
    parameter int ASSERT_CYCLES  = DEFAULT_ASSERT_CYCLES,
    parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES,
    parameter int STUCK_CYCLES   = DEFAULT_STUCK_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    jam_sensor_conditioner_if.slave   ch
);

    localparam int CW = cnt_width(ASSERT_CYCLES, RELEASE_CYCLES);

    logic          s1;
    logic          s;
    logic          q;
    logic          rise_r;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] th;

    // Threshold depends on which way the filter would move.
    assign th      = q ? CW'(RELEASE_CYCLES) : CW'(ASSERT_CYCLES);
    assign cnt_inc = cnt + CW'(1);

    // Two-flop synchronizer; raw feeds nothing else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= ch.raw;
            s  <= s1;
        end
    end

    // Persistence filter: count consecutive disagreeing cycles, flip q at
    // threshold, restart whenever s returns to q. Rise pulses on 0->1 only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= 1'b0;
            cnt    <= '0;
            rise_r <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            if (s == q) begin
                cnt <= '0;
            end else if (cnt_inc == th) begin
                q      <= s;
                cnt    <= '0;
                rise_r <= s;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] stuck_cnt;
    logic          fault_r;

    // Saturating count of cycles spent asserted; fault is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt <= '0;
            fault_r   <= 1'b0;
        end else begin
            if (!q) begin
                stuck_cnt <= '0;
            end else if (stuck_cnt != SW'(STUCK_CYCLES)) begin
                stuck_cnt <= stuck_cnt + SW'(1);
            end
            if (q && (stuck_cnt == STUCK_LAST)) begin
                fault_r <= 1'b1;
            end
        end
    end

    assign ch.jam   = q & ~fault_r;
    assign ch.rise  = rise_r & ~fault_r;
    assign ch.fault = fault_r;
`else
    assign ch.jam   = q;
    assign ch.rise  = rise_r;
    assign ch.fault = 1'b0;
`endif

endmodule

// File: rtl/jam_sensor_conditioner.sv
// Conditions the four raw road-side jam detectors for the traffic
// controller: one independent jam_debounce_ch per road plus an aggregate
// jam flag. Optional stuck-channel detection is built when STUCK_DETECT_EN
// is defined; otherwise sensor_fault is tied low.
module jam_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int ASSERT_CYCLES  = DEFAULT_ASSERT_CYCLES,
    parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES,
    parameter int STUCK_CYCLES   = DEFAULT_STUCK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_jam_0,
    input  logic       raw_jam_1,
    input  logic       raw_jam_2,
    input  logic       raw_jam_3,
    output logic       jam_sensor_0,
    output logic       jam_sensor_1,
    output logic       jam_sensor_2,
    output logic       jam_sensor_3,
    output logic [3:0] jam_rise,
    output logic       jam_any,
    output logic [3:0] sensor_fault
);

    road_mask_t raw_v;
    road_mask_t jam_v;
    road_mask_t rise_v;
    road_mask_t fault_v;

    assign raw_v = {raw_jam_3, raw_jam_2, raw_jam_1, raw_jam_0};

    for (genvar g = 0; g < NUM_ROADS; g++) begin : g_ch
        jam_sensor_conditioner_if ch_if ();

        assign ch_if.raw = raw_v[g];

        jam_debounce_ch #(
            .ASSERT_CYCLES  (ASSERT_CYCLES),
            .RELEASE_CYCLES (RELEASE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ch    (ch_if.slave)
        );

        assign jam_v[g]   = ch_if.jam;
        assign rise_v[g]  = ch_if.rise;
        assign fault_v[g] = ch_if.fault;
    end

    assign jam_sensor_0 = jam_v[0];
    assign jam_sensor_1 = jam_v[1];
    assign jam_sensor_2 = jam_v[2];
    assign jam_sensor_3 = jam_v[3];
    assign jam_rise     = rise_v;
    assign sensor_fault = fault_v;
    // Channel outputs are already fault-masked, so the OR is post-mask.
    assign jam_any      = |jam_v;

endmodule

// File: doc/jam_sensor_conditioner.md
Name: jam_sensor_conditioner

Overview:
- Front-end stage that conditions the four raw road-side jam detectors before they reach the traffic controller's jam_sensor_0..3 inputs.
- Per channel it does three things: a 2-flop synchronizer, a symmetric-hysteresis persistence filter, and a one-cycle rise pulse.
- It also produces an aggregate jam flag.
- The goal is that glitches, chatter and asynchronous field signals never cause spurious controller mode changes.

Parameters:
- ASSERT_CYCLES, 8: consecutive synchronized-high cycles required to assert a channel; legal range ≥1.
- RELEASE_CYCLES, 16: consecutive synchronized-low cycles required to release a channel; legal range ≥1.
- STUCK_CYCLES, 1024: continuous-asserted cycles after which a channel is declared faulty; used only when STUCK_DETECT_EN is defined; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- raw_jam_0  in  1  raw detector road 0, asynchronous to clk
- raw_jam_1  in  1  raw detector road 1, asynchronous to clk
- raw_jam_2  in  1  raw detector road 2, asynchronous to clk
- raw_jam_3  in  1  raw detector road 3, asynchronous to clk
- jam_sensor_0  out  1  conditioned jam, road 0
- jam_sensor_1  out  1  conditioned jam, road 1
- jam_sensor_2  out  1  conditioned jam, road 2
- jam_sensor_3  out  1  conditioned jam, road 3
- jam_rise  out  4  one-cycle pulse per channel when its conditioned output rises
- jam_any  out  1  OR of the four conditioned outputs
- sensor_fault  out  4  sticky per-channel stuck fault; tied 0 when the feature is out

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous assert, synchronous-safe deassert (external).
  - While rst_n=0, every flop clears: sync stages, counters, filtered state q, jam_rise, sensor_fault, all outputs = 0.
  - Reset mid-count discards all progress; there is no memory of the previous state.
- Synchronizer:
  - raw -> s1 -> s (two flops per channel); no other logic touches raw.
- Filter, per channel. State q (1 bit) and counter cnt, with width $clog2(max(ASSERT_CYCLES,RELEASE_CYCLES)+1). Each clock edge:
  - s==q: cnt<=0.
  - s!=q and cnt+1 < TH: cnt<=cnt+1. TH = ASSERT_CYCLES if q==0, else RELEASE_CYCLES.
  - s!=q and cnt+1 == TH: q<=s, cnt<=0.
  - The counter never wraps; it is cleared at threshold or whenever s returns to q.
- Latency:
  - If raw is sampled high at edge E and held, jam_sensor_n rises at edge E+1+ASSERT_CYCLES.
  - Release behaves symmetrically with RELEASE_CYCLES.
  - A pulse of width < TH cycles (as seen at s) produces no output change.
  - Chatter restarts the count on every return to q.
- jam_rise[n]:
  - Registered; asserted for exactly the one cycle following the edge where q goes 0->1.
  - Never asserts on release.
- jam_any: combinational OR of the conditioned outputs (post-mask when the feature is in).
- Channel independence: channels are fully independent; simultaneous transitions on several channels are all honoured in the same cycle.
- No handshake: outputs are level signals consumed every cycle.

Optional Feature:
- Macro: STUCK_DETECT_EN.
- Defined:
  - Each channel has a stuck counter, saturating at STUCK_CYCLES, that increments every cycle q==1 and clears when q==0.
  - On reaching STUCK_CYCLES, sensor_fault[n] sets. It is sticky and cleared only by rst_n.
  - While sensor_fault[n]=1, jam_sensor_n, jam_rise[n] and the channel's jam_any contribution are forced 0. The filter keeps running internally.
- Undefined:
  - No stuck counters; sensor_fault = 4'b0000.
  - Outputs come directly from q.

Decomposition:
- Shared package traffic_pkg:
  - NUM_ROADS=4.
  - Default ASSERT_CYCLES, RELEASE_CYCLES and STUCK_CYCLES constants.
  - Counter-width function.
- Sub-module jam_debounce_ch:
  - Contains one channel's synchronizer, filter, rise pulse and (conditionally) stuck logic.
  - Instantiated four times by jam_sensor_conditioner.

Test Plan:
- Reset behaviour: hold raw_jam_0=1 through reset; release rst_n -> jam_sensor_0 rises exactly 1+8 cycles after the first post-reset sampling edge; jam_rise[0] high for 1 cycle; jam_any=1.
- Glitch rejection: raw_jam_1 high for 7 cycles then low -> jam_sensor_1 stays 0, jam_rise[1] never pulses; repeat with 8 cycles -> asserts.
- Release hysteresis: channel 2 asserted, raw low 15 cycles then high 1 then low 16 -> output stays high through the 15, falls after the final 16th low cycle; no jam_rise.
- Simultaneous channels: all four raw inputs rise on the same edge -> all outputs and jam_rise bits assert in the same cycle; jam_any follows.
- Mid-operation reset: assert rst_n=0 while channel 3 is at cnt=5 -> outputs 0 immediately (asynchronously); after release, a full 8-cycle qualification is required again.
- Stuck fault (STUCK_DETECT_EN): hold raw_jam_0 high 1024 cycles past assertion -> sensor_fault[0]=1 and jam_sensor_0=0; dropping raw keeps the fault until reset; without the macro, sensor_fault stays 0 and the output stays high.
